rgbled_stream_decoder: RTL and testbench



---
 rtl/rgbled_stream_decoder_pkg.sv | 14 +
 rtl/rgbled_stream_decoder_sync.sv | 28 ++
 rtl/rgbled_stream_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_rgbled_stream_decoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgbled_stream_decoder_pkg.sv
// Shared definitions for the RGB LED stream decoder.
//   RGBLED_WORD_W      : bits per colour word (GRB, 8 bits each)
//   rgbled_dec_state_e : line-state FSM encoding
package rgbled_stream_decoder_pkg;

  localparam int unsigned RGBLED_WORD_W = 24;

  typedef enum logic [1:0] {
    SYNC,
    LOW,
    HIGH
  } rgbled_dec_state_e;

endpackage

// File: rtl/rgbled_stream_decoder_sync.sv
// Two-flop synchroniser for the asynchronous serial input.
// Ports:
//   clk_i : system clock
//   rst_i : synchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronised output (two cycles of latency)
module rgbled_stream_decoder_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/rgbled_stream_decoder.sv
// Decodes a WS2812-style single-wire GRB stream into 24-bit colour words.
// Ports:
//   clk_i        : system clock
//   rst_i        : synchronous active-high reset
//   data_i       : asynchronous serial stream
//   word_o       : decoded word, first-received bit in bit 23
//   word_valid_o : word_o holds an undelivered word
//   word_ready_i : consumer accepts word_o
//   latch_o      : one-cycle pulse when a latch gap ends a frame
//   word_count_o : words completed in the current frame (saturating)
//   err_o        : one-cycle pulse on pulse error or partial word at latch
//   overflow_o   : sticky, a completed word was dropped
//   clear_i      : clears overflow_o
module rgbled_stream_decoder
  import rgbled_stream_decoder_pkg::*;
#(
  parameter int unsigned BitThreshCycles = 18,
  parameter int unsigned GlitchCycles    = 3,
  parameter int unsigned MaxHighCycles   = 45,
  parameter int unsigned ResetCycles     = 1500,
  parameter bit          InvertIn        = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     data_i,
  output logic [RGBLED_WORD_W-1:0] word_o,
  output logic                     word_valid_o,
  input  logic                     word_ready_i,
  output logic                     latch_o,
  output logic [15:0]              word_count_o,
  output logic                     err_o,
  output logic                     overflow_o,
  input  logic                     clear_i
);

  localparam int unsigned LowW  = $clog2(ResetCycles + 1);
  localparam int unsigned HighW = $clog2(MaxHighCycles + 2);
  localparam int unsigned BitW  = $clog2(RGBLED_WORD_W + 1);

  localparam logic [LowW-1:0]  LowMax    = LowW'(ResetCycles);
  localparam logic [LowW-1:0]  LowGap    = LowW'(ResetCycles - 1);
  localparam logic [HighW-1:0] HighMax   = HighW'(MaxHighCycles + 1);
  localparam logic [HighW-1:0] HighLimit = HighW'(MaxHighCycles);
  localparam logic [HighW-1:0] HighOne   = HighW'(BitThreshCycles);
  localparam logic [HighW-1:0] HighMin   = HighW'(GlitchCycles);
  localparam logic [BitW-1:0]  LastBit   = BitW'(RGBLED_WORD_W - 1);

  logic data_sync, data_s, data_q, rise, fall;

  rgbled_stream_decoder_sync u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (data_i),
    .q_o   (data_sync)
  );

  assign data_s = data_sync ^ InvertIn;
  assign rise   = ~data_q & data_s;
  assign fall   = data_q & ~data_s;

  rgbled_dec_state_e          state_q, state_d;
  logic [LowW-1:0]            low_cnt_q, low_cnt_d;
  logic [HighW-1:0]           high_cnt_q, high_cnt_d;
  logic [BitW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [RGBLED_WORD_W-2:0]   shift_q, shift_d;
  logic [RGBLED_WORD_W-1:0]   word_q, word_d, new_word;
  logic                       valid_q, valid_d;
  logic                       latch_q, latch_d;
  logic                       err_q, err_d;
  logic                       gap_q, gap_d;
  logic [15:0]                wcnt_q, wcnt_d;
  logic                       ovf_q, ovf_d;
  logic                       bit_val, word_done;

  assign bit_val  = (high_cnt_q >= HighOne);
  assign new_word = {shift_q, bit_val};

  always_comb begin
    state_d    = state_q;
    low_cnt_d  = low_cnt_q;
    high_cnt_d = high_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    word_d     = word_q;
    valid_d    = valid_q;
    latch_d    = 1'b0;
    err_d      = 1'b0;
    gap_d      = 1'b0;
    wcnt_d     = wcnt_q;
    ovf_d      = ovf_q;
    word_done  = 1'b0;

    // Frame count is cleared one cycle after the gap so latch_o sees the final count.
    if (gap_q) wcnt_d = '0;
    if (valid_q && word_ready_i) valid_d = 1'b0;
    if (clear_i) ovf_d = 1'b0;

    unique case (state_q)
      SYNC: begin
        if (data_s) begin
          low_cnt_d = '0;
        end else if (low_cnt_q == LowMax) begin
          state_d = LOW;
        end else begin
          low_cnt_d = low_cnt_q + 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          state_d    = HIGH;
          // The rise cycle is already the first high cycle of the pulse.
          high_cnt_d = HighW'(1);
        end else if (low_cnt_q != LowMax) begin
          low_cnt_d = low_cnt_q + 1'b1;
          if (low_cnt_q == LowGap) begin
            if (bit_cnt_q != '0) begin
              err_d = 1'b1;
            end else if (wcnt_q != '0) begin
              latch_d = 1'b1;
            end
            bit_cnt_d = '0;
            gap_d     = 1'b1;
          end
        end
      end
      HIGH: begin
        if (high_cnt_q > HighLimit) begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
          low_cnt_d = '0;
          state_d   = SYNC;
        end else if (fall) begin
          if (high_cnt_q >= HighMin) begin
            shift_d = new_word[RGBLED_WORD_W-2:0];
            if (bit_cnt_q == LastBit) begin
              word_done = 1'b1;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          low_cnt_d = '0;
          state_d   = LOW;
        end else if (high_cnt_q != HighMax) begin
          high_cnt_d = high_cnt_q + 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase

    if (word_done) begin
      if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
      if (!valid_q || word_ready_i) begin
        word_d  = new_word;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q     <= 1'b0;
      state_q    <= SYNC;
      low_cnt_q  <= '0;
      high_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      latch_q    <= 1'b0;
      err_q      <= 1'b0;
      gap_q      <= 1'b0;
      wcnt_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      data_q     <= data_s;
      state_q    <= state_d;
      low_cnt_q  <= low_cnt_d;
      high_cnt_q <= high_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      latch_q    <= latch_d;
      err_q      <= err_d;
      gap_q      <= gap_d;
      wcnt_q     <= wcnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign latch_o      = latch_q;
  assign err_o        = err_q;
  assign word_count_o = wcnt_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_rgbled_stream_decoder.sv
// Self-checking bench for rgbled_stream_decoder: directed frames with randomized
// pulse widths, checked against a pulse-level model of the line protocol.
module tb_rgbled_stream_decoder;
  import rgbled_stream_decoder_pkg::*;

  localparam int R = 1500;

  logic        clk = 1'b0;
  logic        rst, data, ready, clear;
  logic [23:0] word;
  logic        valid, latch, err, ovf;
  logic [15:0] wc;

  always #5 clk = ~clk;

  rgbled_stream_decoder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .word_o       (word),
    .word_valid_o (valid),
    .word_ready_i (ready),
    .latch_o      (latch),
    .word_count_o (wc),
    .err_o        (err),
    .overflow_o   (ovf),
    .clear_i      (clear)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  bit          m_synced = 0;
  int          m_bits = 0;
  logic [23:0] m_shift = '0;
  int          m_wc = 0;
  bit          m_pending = 0;
  bit          m_ovf = 0;
  logic [23:0] exp_q[$];
  int          exp_latch_wc[$];
  int          exp_err = 0;
  int          exp_latch = 0;

  // Observations
  logic [23:0] rx_q[$];
  int          obs_latch_wc[$];
  int          obs_err = 0;
  int          obs_latch = 0;
  int          valid_cycles = 0;
  int          first_valid_cyc = 0;
  int          latch_cyc = 0;
  int          last_fall_cyc = 0;
  bit          prev_valid = 0;
  bit          prev_taken = 0;
  logic [23:0] prev_word = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) rx_q.push_back(word);
      if (valid) valid_cycles++;
      if (valid && !prev_valid) first_valid_cyc = cyc;
      if (prev_valid && !prev_taken && valid) check("word_stable", word, prev_word);
      if (err) obs_err++;
      if (latch) begin
        obs_latch++;
        obs_latch_wc.push_back(int'(wc));
        latch_cyc = cyc;
      end
      if (err || latch) check("err_latch_excl", {31'd0, err & latch}, 32'd0);
    end
    prev_valid = valid && !rst;
    prev_taken = valid && ready;
    prev_word  = word;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_pulse(input int hi);
    if (!m_synced) return;
    if (hi > 45) begin
      exp_err++;
      m_bits   = 0;
      m_synced = 0;
    end else if (hi >= 3) begin
      m_shift = {m_shift[22:0], (hi >= 18)};
      m_bits++;
      if (m_bits == 24) begin
        m_bits = 0;
        m_wc++;
        if (!m_pending || ready) begin
          exp_q.push_back(m_shift);
          m_pending = !ready;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_synced = 0;
    m_bits   = 0;
    m_wc     = 0;
    if (m_pending) void'(exp_q.pop_back());
    m_pending = 0;
    m_ovf     = 0;
  endtask

  task automatic send_pulse(input int hi, input int lo);
    data = 1'b1;
    repeat (hi) tick();
    data = 1'b0;
    last_fall_cyc = cyc;
    repeat (lo) tick();
    model_pulse(hi);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n, input bit rnd);
    logic b;
    for (int i = n - 1; i >= 0; i--) begin
      b = w[i];
      if (rnd) send_pulse(b ? int'($urandom_range(18, 45)) : int'($urandom_range(3, 17)),
                          int'($urandom_range(10, 30)));
      else send_pulse(b ? 24 : 12, b ? 14 : 26);
    end
  endtask

  task automatic gap(input int n);
    data = 1'b0;
    repeat (n) tick();
    if (m_synced) begin
      if (m_bits != 0) exp_err++;
      else if (m_wc != 0) begin
        exp_latch++;
        exp_latch_wc.push_back(m_wc);
      end
    end
    m_bits   = 0;
    m_wc     = 0;
    m_synced = 1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_nwords"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_word"}, rx_q.pop_front(), exp_q.pop_front());
    rx_q.delete();
    exp_q.delete();
    check({tag, "_nlatch"}, obs_latch, exp_latch);
    check({tag, "_nerr"}, obs_err, exp_err);
    while (obs_latch_wc.size() > 0 && exp_latch_wc.size() > 0)
      check({tag, "_latch_wc"}, obs_latch_wc.pop_front(), exp_latch_wc.pop_front());
    obs_latch_wc.delete();
    exp_latch_wc.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_word"}, word, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_latch"}, latch, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_wc"}, wc, 0);
  endtask

  initial begin
    logic [23:0] w;
    int d;
    rst = 1'b1; data = 1'b0; ready = 1'b1; clear = 1'b0;
    repeat (4) tick();
    check_zero("reset");
    rst = 1'b0;

    // Single word with nominal timing
    gap(1800);
    valid_cycles = 0;
    send_bits(24'hA53C81, 24, 0);
    repeat (6) tick();
    check("single_valid_cycles", valid_cycles, 1);
    d = first_valid_cyc - last_fall_cyc;
    check("single_valid_latency", {31'd0, (d >= 3 && d <= 4)}, 1);
    gap(1600);
    d = latch_cyc - last_fall_cyc;
    check("single_latch_timing", {31'd0, (d >= R + 3 && d <= R + 4)}, 1);
    check("single_wc_cleared", wc, 0);
    compare_all("single");

    // Backpressure: three words, consumer stalled
    gap(1600);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) send_bits(24'($urandom), 24, 1);
    repeat (4) tick();
    check("bp_valid", valid, 1);
    check("bp_word_held", word, exp_q[0]);
    check("bp_ovf", ovf, m_ovf);
    check("bp_wc", wc, m_wc);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_ovf = 0;
    tick();
    check("bp_ovf_cleared", ovf, m_ovf);
    ready = 1'b1;
    m_pending = 0;
    repeat (3) tick();
    gap(1600);
    compare_all("bp");

    // Thresholds: 17 -> 0, 18 -> 1, 2 -> ignored, 45 -> 1 (legal)
    gap(1600);
    send_pulse(17, 20);
    send_pulse(18, 20);
    send_pulse(2, 20);
    send_pulse(45, 20);
    send_bits(24'($urandom), 21, 1);
    repeat (4) tick();
    check("thr_no_err", obs_err, exp_err);
    gap(1600);
    compare_all("thr");
    send_pulse(46, 20);
    repeat (2) tick();
    check("thr_err46", obs_err, exp_err);
    check("thr_fsm_sync", dut.state_q, SYNC);
    send_bits(24'($urandom), 24, 1);  // ignored until a full gap
    gap(1600);
    send_bits(24'($urandom), 24, 1);
    gap(1600);
    compare_all("thr_resync");

    // Partial word then idle
    send_bits(24'($urandom), 10, 1);
    gap(1600);
    check("partial_err", obs_err, exp_err);
    check("partial_no_latch", obs_latch, exp_latch);
    send_bits(24'($urandom), 24, 1);
    gap(1600);
    compare_all("partial");

    // Reset released while the stream is running
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) send_pulse(24, 14);
    data = 1'b1;
    repeat (8) tick();
    rst = 1'b0;
    repeat (12) tick();
    data = 1'b0;
    repeat (14) tick();
    send_bits(24'($urandom), 24, 1);
    repeat (4) tick();
    check("startup_no_word", rx_q.size(), 0);
    check("startup_valid", valid, 0);
    gap(1600);
    send_bits(24'($urandom), 24, 1);
    gap(1600);
    compare_all("startup");

    // Reset in the middle of a word with an undelivered word held
    ready = 1'b0;
    w = 24'($urandom);
    send_bits(w, 24, 1);
    send_bits(24'($urandom), 12, 1);
    check("rstmid_valid_before", valid, 1);
    rst = 1'b1;
    repeat (2) tick();
    check_zero("rstmid");
    model_reset();
    rst = 1'b0;
    ready = 1'b1;
    gap(1600);
    send_bits(24'($urandom), 24, 1);
    send_bits(24'($urandom), 24, 0);
    gap(1600);
    compare_all("rstmid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
